// File: rtl/innerproduct_mac.sv
// innerproduct_mac: theta . x inner product with a per-element enable mask.
// Element 0 is a bias term loaded into the accumulator at acceptance;
// elements 1..NFEAT-1 are multiplied and summed LANES at a time, modulo 2^W.
module innerproduct_mac #(
    parameter int               W         = 32,
    parameter int               NFEAT     = 41,
    parameter int               LANES     = 4,
    parameter logic [NFEAT-1:0] MASK_INIT = '1,
    localparam int              AW        = $clog2(NFEAT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 th_we,
    input  logic [AW-1:0]        th_addr,
    input  logic [W-1:0]         th_wdata,
    input  logic                 mask_we,
    input  logic [NFEAT-1:0]     mask_wdata,
    input  logic                 x_valid,
    output logic                 x_ready,
    input  logic [NFEAT*W-1:0]   x_data,
    output logic                 h_valid,
    input  logic                 h_ready,
    output logic [W-1:0]         h_data,
    output logic                 busy
);

    localparam int IW = $clog2(NFEAT + LANES) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t                   state;
    state_t                   state_nx;
    logic                     live;
    logic                     accept;
    logic                     last_grp;
    logic [W-1:0]             theta [NFEAT];
    logic [NFEAT-1:0]         mask;
    logic [(NFEAT-1)*W-1:0]   xreg;
    logic [W-1:0]             acc;
    logic [W-1:0]             acc_sum;
    logic [W-1:0]             prod;
    logic [IW-1:0]            idx;
    int unsigned              e;
    logic [AW-1:0]            ea;
    logic                     unused_bias_x;

    // The bias slot of the input vector is never used.
    assign unused_bias_x = ^x_data[W-1:0];

    assign h_data   = acc;
    assign last_grp = (32'(idx) + 32'(LANES)) >= 32'(NFEAT);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and handshake outputs; outputs are held low while reset is asserted
    // and x_ready waits for the first edge out of reset.
    always_comb begin
        state_nx = state;
        x_ready  = 1'b0;
        h_valid  = 1'b0;
        busy     = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                x_ready = live & rst_n;
                accept  = x_valid & live;
                if (accept) state_nx = ACC;
            end
            ACC: begin
                busy = rst_n;
                if (last_grp) state_nx = DONE;
            end
            DONE: begin
                busy    = rst_n;
                h_valid = rst_n;
                if (h_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // One accumulate group: sum the enabled, in-range lanes starting at idx.
    always_comb begin
        acc_sum = acc;
        e       = 0;
        ea      = '0;
        prod    = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            e  = 32'(idx) + j;
            ea = e[AW-1:0];
            if (e >= 1 && e < 32'(NFEAT) && mask[ea]) begin
                prod    = xreg[(32'(ea) - 1) * W +: W] * theta[ea];
                acc_sum = acc_sum + prod;
            end
        end
    end

    // Configuration registers, vector capture and accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            live <= 1'b0;
            acc  <= '0;
            idx  <= '0;
            xreg <= '0;
            mask <= MASK_INIT;
            for (int unsigned i = 0; i < NFEAT; i++) theta[i] <= '0;
        end else begin
            live <= 1'b1;
            if (state == IDLE) begin
                if (th_we && 32'(th_addr) < 32'(NFEAT)) theta[th_addr] <= th_wdata;
                if (mask_we) mask <= mask_wdata;
            end
            if (accept) begin
                xreg <= x_data[NFEAT*W-1:W];
                acc  <= mask[0] ? theta[0] : '0;
                idx  <= IW'(1);
            end else if (state == ACC) begin
                acc <= acc_sum;
                idx <= idx + IW'(LANES);
            end
        end
    end

endmodule

// File: tb/tb_innerproduct_mac.sv
// Directed bench for innerproduct_mac; three instances cover LANES = 4, 3 and 40.
module tb_innerproduct_mac;

    localparam int W  = 32;
    localparam int NF = 41;
    localparam int XW = NF * W;

    logic            clk = 1'b0;
    logic            rst_n   [3];
    logic            x_valid [3];
    logic            x_ready [3];
    logic            h_valid [3];
    logic            busy    [3];
    logic [W-1:0]    h_data  [3];
    logic            th_we;
    logic [5:0]      th_addr;
    logic [W-1:0]    th_wdata;
    logic            mask_we;
    logic [NF-1:0]   mask_wdata;
    logic            h_ready;
    logic [XW-1:0]   x_data;
    logic [XW-1:0]   xv;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    innerproduct_mac #(.W(W), .NFEAT(NF), .LANES(4)) u_l4 (
        .clk(clk), .rst_n(rst_n[0]), .th_we(th_we), .th_addr(th_addr), .th_wdata(th_wdata),
        .mask_we(mask_we), .mask_wdata(mask_wdata), .x_valid(x_valid[0]), .x_ready(x_ready[0]),
        .x_data(x_data), .h_valid(h_valid[0]), .h_ready(h_ready), .h_data(h_data[0]), .busy(busy[0])
    );

    innerproduct_mac #(.W(W), .NFEAT(NF), .LANES(3)) u_l3 (
        .clk(clk), .rst_n(rst_n[1]), .th_we(th_we), .th_addr(th_addr), .th_wdata(th_wdata),
        .mask_we(mask_we), .mask_wdata(mask_wdata), .x_valid(x_valid[1]), .x_ready(x_ready[1]),
        .x_data(x_data), .h_valid(h_valid[1]), .h_ready(h_ready), .h_data(h_data[1]), .busy(busy[1])
    );

    innerproduct_mac #(.W(W), .NFEAT(NF), .LANES(40)) u_l40 (
        .clk(clk), .rst_n(rst_n[2]), .th_we(th_we), .th_addr(th_addr), .th_wdata(th_wdata),
        .mask_we(mask_we), .mask_wdata(mask_wdata), .x_valid(x_valid[2]), .x_ready(x_ready[2]),
        .x_data(x_data), .h_valid(h_valid[2]), .h_ready(h_ready), .h_data(h_data[2]), .busy(busy[2])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic reset_all();
        for (int i = 0; i < 3; i++) begin
            rst_n[i]   = 1'b0;
            x_valid[i] = 1'b0;
        end
        th_we = 1'b0; mask_we = 1'b0; h_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_xrdy", x_ready[0], 1'b0);
        check("rst_hval", h_valid[0], 1'b0);
        check("rst_busy", busy[0], 1'b0);
        check("rst_hdat", h_data[0], 0);
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        #1 check("xrdy_pre_edge", x_ready[0], 1'b0);
        @(negedge clk);
        check("xrdy_post_edge", x_ready[0], 1'b1);
    endtask

    task automatic wr_theta(input int a, input logic [W-1:0] v);
        th_we = 1'b1; th_addr = 6'(a); th_wdata = v;
        @(negedge clk);
        th_we = 1'b0;
    endtask

    task automatic wr_mask(input logic [NF-1:0] v);
        mask_we = 1'b1; mask_wdata = v;
        @(negedge clk);
        mask_we = 1'b0;
    endtask

    task automatic start_vec(input int d, input logic [XW-1:0] x, input int c, input string tag,
                             input logic we, input int a, input logic [W-1:0] v);
        int n;
        n = 0;
        while (!x_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_xrdy"}, x_ready[d], 1'b1);
        x_valid[d] = 1'b1; x_data = x;
        th_we = we; th_addr = 6'(a); th_wdata = v;
        @(negedge clk);
        x_valid[d] = 1'b0; th_we = 1'b0;
        n = 0;
        while (!h_valid[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(c));
    endtask

    task automatic finish_vec(input int d, input logic [W-1:0] exp, input string tag);
        check({tag, "_h"}, h_data[d], exp);
        h_ready = 1'b1;
        @(negedge clk);
        h_ready = 1'b0;
        check({tag, "_idle"}, {h_valid[d], x_ready[d]}, 2'b01);
    endtask

    task automatic vec(input int d, input logic [XW-1:0] x, input int c,
                       input logic [W-1:0] exp, input string tag);
        start_vec(d, x, c, tag, 1'b0, 0, '0);
        finish_vec(d, exp, tag);
    endtask

    // Reset lands on ACC edge min(4, C) of an in-flight vector on instance d.
    task automatic mid_reset(input int d, input int c, input string tag);
        int nr;
        bit seen;
        nr = (c < 4) ? c : 4;
        check({tag, "_acc_xrdy"}, x_ready[d], 1'b1);
        x_valid[d] = 1'b1; x_data = xv;
        @(negedge clk);
        x_valid[d] = 1'b0;
        repeat (nr - 1) @(negedge clk);
        check({tag, "_inacc"}, {busy[d], h_valid[d]}, 2'b10);
        rst_n[d] = 1'b0;
        @(negedge clk);
        check({tag, "_during"}, {x_ready[d], h_valid[d], busy[d]}, 3'b000);
        check({tag, "_hdat0"}, h_data[d], 0);
        rst_n[d] = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (h_valid[d]) seen = 1'b1;
        end
        check({tag, "_nohval"}, seen, 1'b0);
        check({tag, "_idle"}, {x_ready[d], busy[d]}, 2'b10);
        vec(d, xv, c, 0, {tag, "_thclr"});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0;
            x_valid[i] = 1'b0;
        end
        th_we = 1'b0; th_addr = '0; th_wdata = '0;
        mask_we = 1'b0; mask_wdata = '0; h_ready = 1'b0; x_data = '0;

        // No theta written: result is zero.
        reset_all();
        xv = '0;
        for (int i = 0; i < NF; i++) xv[i*W +: W] = 32'(i * 7 + 3);
        vec(0, xv, 10, 0, "zero");

        // Bias 5 plus sum of 1..40.
        wr_theta(0, 5);
        for (int i = 1; i < NF; i++) wr_theta(i, 1);
        xv = '0;
        for (int i = 1; i < NF; i++) xv[i*W +: W] = 32'(i);
        vec(0, xv, 10, 825, "full");

        // Out-of-range theta addresses change nothing.
        wr_theta(41, 32'h1000);
        wr_theta(63, 32'h2000);
        vec(0, xv, 10, 825, "badaddr");

        // Mask gating element 1.
        reset_all();
        wr_theta(1, 7);
        xv = '0; xv[1*W +: W] = 3;
        wr_mask(~41'b10);
        vec(0, xv, 10, 0, "mask_off");
        wr_mask('1);
        vec(0, xv, 10, 21, "mask_on");
        wr_mask(~41'b1);
        wr_theta(0, 50);
        vec(0, xv, 10, 21, "bias_off");

        // Modulo-2^W wrap.
        reset_all();
        wr_theta(2, 32'hFFFF_FFFF);
        wr_theta(0, 3);
        xv = '0; xv[2*W +: W] = 2;
        vec(0, xv, 10, 1, "wrap");

        // Backpressure: result held, writes while DONE are dropped.
        start_vec(0, xv, 10, "bp", 1'b0, 0, '0);
        for (int k = 0; k < 5; k++) begin
            check("bp_hold", {h_valid[0], x_ready[0], busy[0], h_data[0]}, {3'b101, 32'h1});
            if (k == 0) begin
                th_we = 1'b1; th_addr = 6'd2; th_wdata = 32'h10;
                mask_we = 1'b1; mask_wdata = '0;
            end
            @(negedge clk);
            th_we = 1'b0; mask_we = 1'b0;
        end
        finish_vec(0, 1, "bp");
        vec(0, xv, 10, 1, "bp_after");

        // Write on the accepting edge: products see it, bias does not.
        start_vec(0, xv, 10, "wacc_th", 1'b1, 2, 5);
        finish_vec(0, 13, "wacc_th");
        start_vec(0, xv, 10, "wacc_bias", 1'b1, 0, 100);
        finish_vec(0, 13, "wacc_bias");
        vec(0, xv, 10, 110, "wacc_next");

        // Reset in the middle of accumulation for each lane count.
        for (int d = 0; d < 3; d++) begin
            int c;
            c = (d == 0) ? 10 : (d == 1) ? 14 : 1;
            reset_all();
            wr_theta(0, 9);
            wr_theta(1, 2);
            xv = '0;
            for (int i = 0; i < NF; i++) xv[i*W +: W] = 1;
            vec(d, xv, c, 11, $sformatf("mr%0d_pre", d));
            mid_reset(d, c, $sformatf("mr%0d", d));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/innerproduct_mac.md
INNERPRODUCT_MAC -- requirements
Module: innerproduct_mac

Interface
REQ-001 Parameter W, default 32: data, theta and result width in bits.
REQ-002 Parameter NFEAT, default 41: vector length; element 0 is the bias slot, elements 1..NFEAT-1 are features.
REQ-003 Parameter LANES, default 4: multipliers used per accumulate cycle; legal range 1..NFEAT-1.
REQ-004 Parameter MASK_INIT, default all ones: reset value of the NFEAT-bit enable mask.
REQ-005 The block SHALL use one clock; reset is synchronous and active-low.
REQ-006 clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 th_we  in  1  theta write strobe.
REQ-009 th_addr  in  clog2(NFEAT)  theta index.
REQ-010 th_wdata  in  W  theta value.
REQ-011 mask_we  in  1  mask write strobe.
REQ-012 mask_wdata  in  NFEAT  per-element enable; bit i enables element i.
REQ-013 x_valid  in  1  input vector valid.
REQ-014 x_ready  out  1  block can accept a vector.
REQ-015 x_data  in  NFEAT*W  element i at bits [i*W +: W]; element 0 is ignored.
REQ-016 h_valid  out  1  result valid.
REQ-017 h_ready  in  1  downstream accepts the result.
REQ-018 h_data  out  W  inner-product result (hprime).
REQ-019 busy  out  1  high in ACC and DONE.

Function
REQ-020 The block SHALL hold NFEAT W-bit theta registers and one NFEAT-bit mask register.
REQ-021 An FSM SHALL have three states: IDLE, ACC and DONE.
REQ-022 x_ready SHALL be 1 only in IDLE, and h_valid SHALL be 1 only in DONE.
REQ-023 On an edge in IDLE with x_valid=1, the block SHALL register x_data and load acc with theta[0] if mask[0] is set, otherwise 0.
REQ-024 On the same edge it SHALL set idx to 1 and move to ACC.
REQ-025 Each ACC edge SHALL add, for every j in 0..LANES-1 with idx+j<NFEAT and mask[idx+j]=1, the low W bits of x[idx+j]*theta[idx+j] to acc.
REQ-026 Each ACC edge SHALL then advance idx by LANES.
REQ-027 The final ACC group SHALL be partial when (NFEAT-1) is not a multiple of LANES; out-of-range lanes contribute 0.
REQ-028 All arithmetic SHALL be modulo 2^W and sign-agnostic: the low W bits of the products and sums only.
REQ-029 ACC SHALL last exactly C=ceil((NFEAT-1)/LANES) edges, i.e. 10 at the defaults.
REQ-030 h_valid SHALL rise after edge k+C, where k is the accepting edge, and h_data SHALL equal acc.
REQ-031 In DONE, h_data and h_valid SHALL hold stable until an edge with h_ready=1; that edge returns the FSM to IDLE.
REQ-032 There SHALL be no bypass from DONE to ACC; the earliest next acceptance is the edge after the handshake edge.
REQ-033 Theta and mask writes SHALL take effect only on edges where state is IDLE.
REQ-034 Theta and mask writes on edges in ACC or DONE SHALL be discarded silently.
REQ-035 A theta write with th_addr>=NFEAT SHALL be discarded.
REQ-036 On an IDLE edge with both a write and x_valid, the vector SHALL be accepted and the write SHALL also land; bias and products use the post-write values from the next edge onward.

Reset
REQ-037 On an edge with rst_n=0, regardless of state, the block SHALL force IDLE, acc=0, idx=0 and h_data=0.
REQ-038 The same reset edge SHALL clear all theta registers to 0 and load mask with MASK_INIT.
REQ-039 The same reset edge SHALL drop any in-flight vector with no result produced.
REQ-040 During reset, x_ready=0, h_valid=0 and busy=0; x_ready returns to 1 on the first edge with rst_n=1.

Verification
REQ-041 After reset with no theta writes, any x -> h_data=0 after 10 edges.
REQ-042 Bias and full sum: theta[0]=5, theta[i]=1 and x[i]=i for i=1..40 -> h_data=825, h_valid exactly 10 edges after acceptance.
REQ-043 Mask: theta[1]=7, x[1]=3, all else 0, mask[1]=0 -> 0; after setting mask[1]=1 -> 21.
REQ-044 Wrap: theta[2]=0xFFFFFFFF, x[2]=2, theta[0]=3 -> h_data=0x00000001.
REQ-045 Backpressure: h_ready=0 for 5 cycles -> h_data stable, x_ready=0, a theta write to index 2 during this time is ignored (proved by a subsequent vector).
REQ-046 Reset mid-ACC: rst_n=0 on the 4th ACC edge -> next state IDLE, h_valid never asserts, theta reads back as 0; repeat with LANES=3 (C=14) and LANES=40 (C=1).
